hash_result_scanner: RTL and testbench



---
 rtl/bitcoin_pkg.sv | 31 +++
 rtl/hash_result_scanner_if.sv | 29 ++
 rtl/hash_min_tracker.sv | 42 ++++
 rtl/hash_result_scanner.sv | 132 +++++++++++++
 tb/tb_hash_result_scanner.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bitcoin_pkg.sv
// Shared types and constants for the hash result scanner: scan states,
// summary-word field positions and the summary packing helper.
package bitcoin_pkg;

  localparam int NUM_NONCES_DEFAULT = 16;

  localparam int FOUND_BIT       = 31;
  localparam int MIN_NONCE_LSB   = 16;
  localparam int FOUND_NONCE_LSB = 0;

  localparam logic [31:0] HASH_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } scan_state_e;

  function automatic logic [31:0] pack_summary(input logic       found,
                                               input logic [7:0] min_nonce,
                                               input logic [7:0] found_nonce);
    logic [31:0] w;
    w = '0;
    w[FOUND_BIT]               = found;
    w[MIN_NONCE_LSB +: 8]      = min_nonce;
    w[FOUND_NONCE_LSB +: 8]    = found_nonce;
    return w;
  endfunction

endpackage

// File: rtl/hash_result_scanner_if.sv
// Control, result and shared-memory signals of the hash result scanner.
// The system controller / memory side uses master, the scanner uses slave.
interface hash_result_scanner_if;
  logic        start;
  logic [15:0] output_addr;
  logic [31:0] target;
  logic        done;
  logic        found;
  logic [7:0]  found_nonce;
  logic [31:0] min_hash;
  logic [7:0]  min_nonce;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    output start, output_addr, target, mem_read_data,
    input  done, found, found_nonce, min_hash, min_nonce,
    input  mem_clk, mem_we, mem_addr, mem_write_data
  );

  modport slave (
    input  start, output_addr, target, mem_read_data,
    output done, found, found_nonce, min_hash, min_nonce,
    output mem_clk, mem_we, mem_addr, mem_write_data
  );
endinterface

// File: rtl/hash_min_tracker.sv
// Running first-below-target and minimum-hash tracker over captured words.
// Strict compares make ties keep the lower (earlier) index.
module hash_min_tracker
  import bitcoin_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        cap_valid,
  input  logic [7:0]  cap_idx,
  input  logic [31:0] cap_data,
  input  logic [31:0] target,
  output logic        found,
  output logic [7:0]  found_nonce,
  output logic [31:0] min_hash,
  output logic [7:0]  min_nonce
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      found       <= 1'b0;
      found_nonce <= 8'd0;
      min_hash    <= HASH_MAX;
      min_nonce   <= 8'd0;
    end else if (clear) begin
      found       <= 1'b0;
      found_nonce <= 8'd0;
      min_hash    <= HASH_MAX;
      min_nonce   <= 8'd0;
    end else if (cap_valid) begin
      if (!found && (cap_data < target)) begin
        found       <= 1'b1;
        found_nonce <= cap_idx;
      end
      if (cap_data < min_hash) begin
        min_hash  <= cap_data;
        min_nonce <= cap_idx;
      end
    end
  end

endmodule

// File: rtl/hash_result_scanner.sv
// Scans NUM_NONCES hash words from shared memory, tracks first-below-target
// and minimum hash, then writes one summary word after the scanned block.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | memory port quiet, waiting for start
// ST_READ  | issuing addresses and capturing returned words
// ST_WRITE | summary word on the bus with mem_we high
// ST_DONE  | done pulse high, back to idle next edge
module hash_result_scanner
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES = NUM_NONCES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  hash_result_scanner_if.slave  bus
);

  localparam logic [7:0]  LAST_IDX  = 8'(NUM_NONCES - 1);
  localparam logic [15:0] SUM_OFFS  = 16'(NUM_NONCES);

  scan_state_e state;
  logic [15:0] base_addr;
  logic [31:0] target_q;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        done;

  // Read-latency tracker: stage 0 is the address on the bus, stage 1 the
  // address whose data arrives at the next edge.
  logic        v0, v1;
  logic [7:0]  idx0, idx1;
  logic        scan_end;

  logic        cap_valid;
  logic        clear;
  logic        found;
  logic [7:0]  found_nonce;
  logic [31:0] min_hash;
  logic [7:0]  min_nonce;

  assign cap_valid = v1 && (state == ST_READ);
  assign clear     = (state == ST_IDLE) && bus.start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      base_addr <= 16'd0;
      target_q  <= 32'd0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'd0;
      mem_wdata <= 32'd0;
      done      <= 1'b0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      idx0      <= 8'd0;
      idx1      <= 8'd0;
      scan_end  <= 1'b0;
    end else begin
      v1       <= v0;
      idx1     <= idx0;
      scan_end <= cap_valid && (idx1 == LAST_IDX);
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            base_addr <= bus.output_addr;
            target_q  <= bus.target;
            mem_we    <= 1'b0;
            mem_addr  <= bus.output_addr;
            v0        <= 1'b1;
            idx0      <= 8'd0;
            state     <= ST_READ;
          end else begin
            v0 <= 1'b0;
          end
        end
        ST_READ: begin
          // scan_end is one edge after the last capture, so the tracker
          // registers already include the final word.
          if (scan_end) begin
            mem_we    <= 1'b1;
            mem_addr  <= base_addr + SUM_OFFS;
            mem_wdata <= pack_summary(found, min_nonce, found_nonce);
            state     <= ST_WRITE;
          end else if (v0 && (idx0 != LAST_IDX)) begin
            mem_addr <= mem_addr + 16'd1;
            idx0     <= idx0 + 8'd1;
          end else begin
            v0 <= 1'b0;
          end
        end
        ST_WRITE: begin
          mem_we <= 1'b0;
          done   <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  hash_min_tracker u_tracker (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .cap_valid   (cap_valid),
    .cap_idx     (idx1),
    .cap_data    (bus.mem_read_data),
    .target      (target_q),
    .found       (found),
    .found_nonce (found_nonce),
    .min_hash    (min_hash),
    .min_nonce   (min_nonce)
  );

  assign bus.mem_clk        = clk;
  assign bus.mem_we         = mem_we;
  assign bus.mem_addr       = mem_addr;
  assign bus.mem_write_data = mem_wdata;
  assign bus.done           = done;
  assign bus.found          = found;
  assign bus.found_nonce    = found_nonce;
  assign bus.min_hash       = min_hash;
  assign bus.min_nonce      = min_nonce;

endmodule

// File: tb/tb_hash_result_scanner.sv
// Randomized bench for hash_result_scanner: a cycle-timeline reference model
// plus a per-cycle compare process and literal expectations from the test plan.
module tb_hash_result_scanner;
  import bitcoin_pkg::*;

  localparam int N = NUM_NONCES_DEFAULT;

  logic clk;
  logic reset_n;
  hash_result_scanner_if bus();

  hash_result_scanner dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // shared single-port memory, two-edge read latency as seen by the scanner
  logic [31:0] mem [65536];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_write_data;
    bus.mem_read_data <= mem[bus.mem_addr];
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit          m_busy;
  int          m_k;
  int          m_cnt;
  logic [15:0] m_base;
  logic [31:0] m_tgt;
  logic [15:0] m_idle_addr;
  logic [31:0] snap [N];

  // results after the first cnt words of the snapshot have been considered
  function automatic void prefix(input int cnt, output logic f, output logic [7:0] fn,
                                 output logic [31:0] mh, output logic [7:0] mn);
    f = 1'b0; fn = 8'd0; mh = 32'hFFFF_FFFF; mn = 8'd0;
    for (int j = 0; j < cnt; j++) begin
      if (!f && snap[j] < m_tgt) begin f = 1'b1; fn = 8'(j); end
      if (snap[j] < mh) begin mh = snap[j]; mn = 8'(j); end
    end
  endfunction

  function automatic logic [31:0] summary(input logic f, input logic [7:0] mn, input logic [7:0] fn);
    return {f, 7'b0, mn, 8'b0, fn};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_k = 0; m_cnt = 0; m_idle_addr = 16'd0;
    end else if (m_busy) begin
      m_k++;
      if (m_k == N + 4) begin
        m_busy = 0; m_cnt = N; m_idle_addr = 16'(m_base + 16'(N));
      end
    end else if (bus.start) begin
      m_busy = 1; m_k = 0; m_base = bus.output_addr; m_tgt = bus.target;
      for (int j = 0; j < N; j++) snap[j] = mem[16'(m_base + 16'(j))];
    end
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      int          cnt;
      logic [15:0] ea;
      logic        ewe, edn, f;
      logic [7:0]  fn, mn;
      logic [31:0] mh;
      if (m_busy) begin
        cnt = (m_k - 1 < 0) ? 0 : ((m_k - 1 > N) ? N : m_k - 1);
        if (m_k <= N - 1)      ea = 16'(m_base + 16'(m_k));
        else if (m_k <= N + 1) ea = 16'(m_base + 16'(N - 1));
        else                   ea = 16'(m_base + 16'(N));
        ewe = (m_k == N + 2);
        edn = (m_k == N + 3);
      end else begin
        cnt = m_cnt; ea = m_idle_addr; ewe = 1'b0; edn = 1'b0;
      end
      prefix(cnt, f, fn, mh, mn);
      check("mem_we", 32'(bus.mem_we), 32'(ewe));
      check("done", 32'(bus.done), 32'(edn));
      check("mem_addr", 32'(bus.mem_addr), 32'(ea));
      check("found", 32'(bus.found), 32'(f));
      check("found_nonce", 32'(bus.found_nonce), 32'(fn));
      check("min_hash", bus.min_hash, mh);
      check("min_nonce", 32'(bus.min_nonce), 32'(mn));
      if (ewe) check("mem_write_data", bus.mem_write_data, summary(f, mn, fn));
    end
  end

  // ---------------- stimulus ----------------
  int          done_e1, done_e2;
  logic [15:0] addr_seen [64];

  // policy 0: one-cycle start; 1: random start/addr/target noise while busy; 2: start held
  task automatic run_scan(input logic [15:0] base, input logic [31:0] tg,
                          input int policy, input int n_edges);
    done_e1 = -1; done_e2 = -1;
    bus.output_addr = base; bus.target = tg; bus.start = 1'b1;
    for (int e = 0; e < n_edges; e++) begin
      @(posedge clk); #1;
      addr_seen[e] = bus.mem_addr;
      if (bus.done) begin
        if (done_e1 < 0) done_e1 = e;
        else if (done_e2 < 0) done_e2 = e;
      end
      case (policy)
        0: bus.start = 1'b0;
        1: begin
          bus.start       = 1'($urandom_range(0, 1));
          bus.output_addr = 16'($urandom);
          bus.target      = $urandom;
        end
        default: bus.start = 1'b1;
      endcase
    end
    bus.start = 1'b0;
  endtask

  task automatic check_results(input string tag, input logic f, input logic [7:0] fn,
                               input logic [31:0] mh, input logic [7:0] mn);
    check({tag, "_found"}, 32'(bus.found), 32'(f));
    check({tag, "_found_nonce"}, 32'(bus.found_nonce), 32'(fn));
    check({tag, "_min_hash"}, bus.min_hash, mh);
    check({tag, "_min_nonce"}, 32'(bus.min_nonce), 32'(mn));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_mem_write_data"}, bus.mem_write_data, 32'd0);
    check_results(tag, 1'b0, 8'd0, 32'hFFFF_FFFF, 8'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.start = 1'b0; bus.output_addr = 16'd0; bus.target = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    check("mem_clk", 32'(bus.mem_clk), 32'(clk));
    @(negedge clk); reset_n = 1'b1; chk_en = 1;
    @(posedge clk); #1;

    // ascending words, nothing below target
    for (int i = 0; i < N; i++) mem[16'h0100 + i] = 32'h1000_0000 + i;
    run_scan(16'h0100, 32'h0000_0001, 0, N + 5);
    check("t1_done_edge", 32'(done_e1), 32'd19);
    check_results("t1", 1'b0, 8'd0, 32'h1000_0000, 8'd0);
    check("t1_summary", mem[16'h0110], 32'h0000_0000);

    // two candidates below target
    for (int i = 0; i < N; i++) mem[16'h0200 + i] = 32'hFFFF_0000;
    mem[16'h0209] = 32'h0000_0005;
    mem[16'h020C] = 32'h0000_0002;
    run_scan(16'h0200, 32'h0000_0010, 0, N + 5);
    check_results("t2", 1'b1, 8'd9, 32'h0000_0002, 8'd12);
    check("t2_summary", mem[16'h0210], 32'h800C_0009);

    // all max, strict compare
    for (int i = 0; i < N; i++) mem[16'h0300 + i] = 32'hFFFF_FFFF;
    run_scan(16'h0300, 32'hFFFF_FFFF, 0, N + 5);
    check_results("t3", 1'b0, 8'd0, 32'hFFFF_FFFF, 8'd0);
    check("t3_summary", mem[16'h0310], 32'h0000_0000);

    // address wrap
    for (int i = 0; i < N; i++) mem[16'(16'hFFF8 + i)] = $urandom_range(100, 1000);
    run_scan(16'hFFF8, 32'd500, 0, N + 5);
    check("t4_addr0", 32'(addr_seen[0]), 32'h0000_FFF8);
    check("t4_addr7", 32'(addr_seen[7]), 32'h0000_FFFF);
    check("t4_addr8", 32'(addr_seen[8]), 32'h0000_0000);
    check("t4_addr15", 32'(addr_seen[15]), 32'h0000_0007);
    check("t4_addr17", 32'(addr_seen[17]), 32'h0000_0007);
    check("t4_addr18", 32'(addr_seen[18]), 32'h0000_0008);
    check("t4_summary", mem[16'h0008], summary(bus.found ? 1'b1 : 1'b0, bus.min_nonce, bus.found_nonce));

    // reset in the middle of a scan
    for (int i = 0; i < N; i++) mem[16'h0500 + i] = $urandom;
    mem[16'h0510] = 32'hDEAD_BEEF;
    bus.output_addr = 16'h0500; bus.target = 32'hFFFF_FFFF; bus.start = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    repeat (N + 6) @(posedge clk);
    #1;
    check("midreset_no_write", mem[16'h0510], 32'hDEAD_BEEF);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    run_scan(16'h0500, 32'h8000_0000, 0, N + 5);
    check("after_reset_done_edge", 32'(done_e1), 32'd19);

    // start held high: second scan only once idle again
    for (int i = 0; i < N; i++) mem[16'h0400 + i] = 32'h0000_0100 - i;
    run_scan(16'h0400, 32'h0000_00F8, 2, 2 * (N + 5));
    check("hold_done1", 32'(done_e1), 32'd19);
    check("hold_done2", 32'(done_e2), 32'd40);
    check_results("hold", 1'b1, 8'd9, 32'h0000_00F1, 8'd15);

    // randomized scans with ties and start/address/target noise while busy
    for (int s = 0; s < 24; s++) begin
      logic [15:0] b;
      logic [31:0] t;
      int          mode;
      b = 16'($urandom);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < N; i++) begin
        case (mode)
          0: mem[16'(b + 16'(i))] = $urandom_range(0, 7);
          1: mem[16'(b + 16'(i))] = $urandom;
          default: mem[16'(b + 16'(i))] = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        endcase
      end
      t = (mode == 0) ? 32'($urandom_range(0, 8)) :
          (mode == 1) ? $urandom : 32'hFFFF_FFF0 + $urandom_range(0, 16);
      run_scan(b, t, $urandom_range(0, 1), N + 5);
      check("rand_done_edge", 32'(done_e1), 32'(N + 3));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
